idma_err_collect: RTL

IDMA_ERR_COLLECT -- requirements
Module: idma_err_collect

---
 rtl/idma_err_collect.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/idma_err_collect.sv
// idma_err_collect: collects error reports from several iDMA backend channels,
// serialises them towards the frontend and returns the frontend's decision
// (CONTINUE/ABORT) to the channel that raised each error.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   ch_err_valid_i/ch_err_ready_o   per-channel error request handshake
//   ch_err_type_i, ch_err_addr_i    per-channel error type (2b) and faulting address
//   ch_action_valid_o/_ready_i      per-channel decision handshake (one-hot valid)
//   ch_action_o                     decision shared by all channels (0=CONTINUE, 1=ABORT)
//   rsp_err_valid_o/rsp_err_ready_i error report handshake to frontend
//   rsp_err_type_o/_addr_o/_ch_o    reported error payload (head of queue)
//   eh_valid_i/eh_ready_o/eh_i      frontend decision handshake
//   busy_o                          an error is queued or being handled
//   timeout_o                       sticky flag: a decision was forced by timeout
//
// Optional feature: define IDMA_EH_TIMEOUT_EN to auto-abort after TimeoutCycles
// cycles without a frontend decision. Without it WAIT_EH waits indefinitely.
// Error type encoding: 0=BUS_READ, 1=BUS_WRITE, 2=BACKEND, 3=ND_MIDEND.

module idma_err_collect #(
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumChannels-1:0]                 ch_err_valid_i,
    output logic [NumChannels-1:0]                 ch_err_ready_o,
    input  logic [2*NumChannels-1:0]               ch_err_type_i,
    input  logic [AddrWidth*NumChannels-1:0]       ch_err_addr_i,
    output logic [NumChannels-1:0]                 ch_action_valid_o,
    output logic                                   ch_action_o,
    input  logic [NumChannels-1:0]                 ch_action_ready_i,
    output logic                                   rsp_err_valid_o,
    input  logic                                   rsp_err_ready_i,
    output logic [1:0]                             rsp_err_type_o,
    output logic [AddrWidth-1:0]                   rsp_err_addr_o,
    output logic [((NumChannels > 1) ? $clog2(NumChannels) : 1)-1:0] rsp_err_ch_o,
    input  logic                                   eh_valid_i,
    output logic                                   eh_ready_o,
    input  logic                                   eh_i,
    output logic                                   busy_o,
    output logic                                   timeout_o
);

    localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned CntW = $clog2(NumChannels + 1);

    typedef enum logic [1:0] {REPORT, WAIT_EH, ISSUE} state_e;
    typedef enum logic {CONTINUE = 1'b0, ABORT = 1'b1} eh_action_e;

    // Elaboration-time parameter sanity checks
    if (NumChannels < 1 || NumChannels > 16) begin : g_bad_channels
        $error("NumChannels must be in 1..16");
    end
    if (TimeoutCycles < 1) begin : g_bad_timeout
        $error("TimeoutCycles must be nonzero");
    end

    function automatic logic [ChW-1:0] ptr_inc(input logic [ChW-1:0] p);
        return (32'(p) == NumChannels - 1) ? '0 : ChW'(32'(p) + 1);
    endfunction

    // Error queue storage; depth equals channel count so it can never overflow
    logic [1:0]            fifo_type_q [NumChannels];
    logic [AddrWidth-1:0]  fifo_addr_q [NumChannels];
    logic [ChW-1:0]        fifo_ch_q   [NumChannels];
    logic [ChW-1:0]        wr_ptr_q, rd_ptr_q, rr_q;
    logic [CntW-1:0]       count_q;
    logic [NumChannels-1:0] outstanding_q;

    state_e     state_q, state_d;
    eh_action_e action_q, action_d;

    logic [NumChannels-1:0] eligible, gnt_mask, pop_mask;
    logic                   gnt_found, pop;
    logic [ChW-1:0]         gnt_idx, head_ch;
    int unsigned            idx;

    assign head_ch = fifo_ch_q[rd_ptr_q];

    // Round-robin grant: first eligible channel at or after rr_q, wrapping
    always_comb begin
        eligible  = ch_err_valid_i & ~outstanding_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NumChannels) idx = idx - NumChannels;
            if (!gnt_found && eligible[ChW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ChW'(idx);
            end
        end
        gnt_mask = gnt_found ? (NumChannels'(1) << gnt_idx) : '0;
    end

    assign ch_err_ready_o = rst_i ? '0 : gnt_mask;
    assign pop_mask       = pop ? (NumChannels'(1) << head_ch) : '0;

    // Queue pointers, occupancy, outstanding mask and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rr_q          <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
        end else begin
            if (gnt_found) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
                rr_q     <= ptr_inc(gnt_idx);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (gnt_found && !pop)      count_q <= count_q + CntW'(1);
            else if (!gnt_found && pop) count_q <= count_q - CntW'(1);
            outstanding_q <= (outstanding_q | gnt_mask) & ~pop_mask;
        end
    end

    // Queue payload storage; validity is tracked by the pointers only
    always_ff @(posedge clk_i) begin
        if (gnt_found) begin
            fifo_type_q[wr_ptr_q] <= ch_err_type_i[2*gnt_idx +: 2];
            fifo_addr_q[wr_ptr_q] <= ch_err_addr_i[AddrWidth*gnt_idx +: AddrWidth];
            fifo_ch_q[wr_ptr_q]   <= gnt_idx;
        end
    end

    assign rsp_err_type_o = fifo_type_q[rd_ptr_q];
    assign rsp_err_addr_o = fifo_addr_q[rd_ptr_q];
    assign rsp_err_ch_o   = head_ch;
    assign ch_action_o    = action_q;
    assign busy_o         = (count_q != '0) || (state_q != REPORT);

`ifdef IDMA_EH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= REPORT;
            action_q  <= CONTINUE;
`ifdef IDMA_EH_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            action_q  <= action_d;
`ifdef IDMA_EH_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // FSM next-state and handshake outputs
    always_comb begin
        state_d           = state_q;
        action_d          = action_q;
        rsp_err_valid_o   = 1'b0;
        eh_ready_o        = 1'b0;
        ch_action_valid_o = '0;
        pop               = 1'b0;
`ifdef IDMA_EH_TIMEOUT_EN
        tmo_cnt_d         = '0;
        timeout_d         = timeout_q;
`endif
        case (state_q)
            REPORT: begin
                rsp_err_valid_o = (count_q != '0);
                if (rsp_err_valid_o && rsp_err_ready_i) state_d = WAIT_EH;
            end
            WAIT_EH: begin
                eh_ready_o = 1'b1;
                if (eh_valid_i) begin
                    action_d = eh_action_e'(eh_i);
                    state_d  = ISSUE;
                end
`ifdef IDMA_EH_TIMEOUT_EN
                else if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) begin
                    action_d  = ABORT;
                    timeout_d = 1'b1;
                    state_d   = ISSUE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
`endif
            end
            ISSUE: begin
                ch_action_valid_o = NumChannels'(1) << head_ch;
                if (ch_action_ready_i[head_ch]) begin
                    pop     = 1'b1;
                    state_d = REPORT;
                end
            end
            default: state_d = REPORT;
        endcase
    end

endmodule
